// File: rtl/vga_scan_gen.sv
// Raster timing generator: row/col scan counters, sync strobes and per-frame pulses, all registered and aligned to row/col.
// Latency: 1 clk from en rising to coordinate change; no backpressure, en=0 freezes the scan and suppresses frame pulses.
module vga_scan_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int F2_ROW   = 500
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  output logic [10:0] o_row,
  output logic [10:0] o_col,
  output logic        o_active,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_frame1,
  output logic        o_frame2,
  output logic [7:0]  o_frame_cnt
);

  localparam logic [10:0] H_TOTAL  = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam logic [10:0] V_TOTAL  = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam logic [10:0] H_ACT_W  = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT_W  = 11'(V_ACTIVE);
  localparam logic [10:0] HS_FIRST = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] VS_FIRST = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_LAST  = 11'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [10:0] F2_ROW_W = 11'(F2_ROW);

  logic [10:0] r_row;
  logic [10:0] r_col;
  logic [7:0]  r_frame_cnt;
  logic        r_active;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_frame1;
  logic        r_frame2;

  logic        w_col_wrap;
  logic        w_row_wrap;
  logic [10:0] w_col_nxt;
  logic [10:0] w_row_nxt;

  assign w_col_wrap = (r_col == H_TOTAL - 11'd1);
  assign w_row_wrap = (r_row == V_TOTAL - 11'd1);
  assign w_col_nxt  = w_col_wrap ? 11'd0 : r_col + 11'd1;
  assign w_row_nxt  = !w_col_wrap ? r_row : (w_row_wrap ? 11'd0 : r_row + 11'd1);

  // Strobes are decoded from the next coordinate so they stay aligned with row/col.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_row       <= 11'd0;
      r_col       <= 11'd0;
      r_frame_cnt <= 8'd0;
      r_active    <= 1'b1;
      r_hsync     <= 1'b1;
      r_vsync     <= 1'b1;
      r_frame1    <= 1'b0;
      r_frame2    <= 1'b0;
    end else if (i_en) begin
      r_row    <= w_row_nxt;
      r_col    <= w_col_nxt;
      r_active <= (w_col_nxt < H_ACT_W) && (w_row_nxt < V_ACT_W);
      r_hsync  <= !((w_col_nxt >= HS_FIRST) && (w_col_nxt <= HS_LAST));
      r_vsync  <= !((w_row_nxt >= VS_FIRST) && (w_row_nxt <= VS_LAST));
      r_frame1 <= (w_row_nxt == V_ACT_W) && (w_col_nxt == 11'd0);
      r_frame2 <= (w_row_nxt == F2_ROW_W) && (w_col_nxt == 11'd0);
      if (w_col_wrap && w_row_wrap) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end else begin
      // Pulses mark a coordinate visit, so a held coordinate must not re-fire them.
      r_frame1 <= 1'b0;
      r_frame2 <= 1'b0;
    end
  end

  assign o_row       = r_row;
  assign o_col       = r_col;
  assign o_active    = r_active;
  assign o_hsync     = r_hsync;
  assign o_vsync     = r_vsync;
  assign o_frame1    = r_frame1;
  assign o_frame2    = r_frame2;
  assign o_frame_cnt = r_frame_cnt;

endmodule
